// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, flush and optional skid.
// Control is masked to zero on bubbles; stall cycles are counted with saturation.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              main_valid_q;
  logic              main_valid_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid_q;
      logic              skid_valid_d;
      logic [DATA_W-1:0] skid_data_q;
      logic [DATA_W-1:0] skid_data_d;
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic [CTRL_W-1:0] skid_ctrl_d;

      // Registered ready: the skid slot absorbs the one in-flight beat.
      assign in_ready = !skid_valid_q;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
          main_valid_d = 1'b0;
          main_data_d  = '0;
          main_ctrl_d  = '0;
          skid_valid_d = 1'b0;
          skid_data_d  = '0;
          skid_ctrl_d  = '0;
        end else if (!main_valid_q || out_fire) begin
          if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
          end else if (in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
          end else begin
            main_valid_d = 1'b0;
          end
        end else if (in_fire) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_ctrl_d  = in_ctrl;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          skid_valid_q <= 1'b0;
          skid_data_q  <= '0;
          skid_ctrl_q  <= '0;
        end else begin
          skid_valid_q <= skid_valid_d;
          skid_data_q  <= skid_data_d;
          skid_ctrl_q  <= skid_ctrl_d;
        end
      end
    end else begin : g_reg
      assign in_ready = !main_valid_q || out_ready;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        if (flush) begin
          main_valid_d = 1'b0;
          main_data_d  = '0;
          main_ctrl_d  = '0;
        end else if (in_fire) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_ctrl_d  = in_ctrl;
        end else if (out_fire) begin
          main_valid_d = 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      stall_q      <= stall_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_data     = main_data_q;
  assign out_ctrl     = main_ctrl_q & {CTRL_W{main_valid_q}};
  assign stall_cycles = stall_q;

endmodule
